// File: rtl/hydra_pkg.sv
// Shared types and helpers for the hydra switch egress path.
// Priority 7 is the most urgent queue; WRR weight of queue p is p+1.
package hydra_pkg;

  localparam int PRIOR_W   = 3;
  localparam int NUM_PRIOR = 8;
  localparam int WEIGHT_W  = 4;

  typedef logic [PRIOR_W-1:0] prior_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_t;

  function automatic logic [WEIGHT_W-1:0] weight(input prior_t p);
    return WEIGHT_W'(p) + WEIGHT_W'(1);
  endfunction

  // Index of the most significant set bit; 0 when the vector is empty.
  function automatic prior_t highest_set(input logic [NUM_PRIOR-1:0] v);
    prior_t r;
    r = '0;
    for (int i = 0; i < NUM_PRIOR; i++) begin
      if (v[i]) r = prior_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/prior_select.sv
// Combinational queue picker: strict priority or credit-gated weighted round robin.
// Raises reload when WRR finds no queue with both packets and credit left.
module prior_select
  import hydra_pkg::*;
(
  input  logic                 wrr_en,
  input  logic [NUM_PRIOR-1:0] cnt_nz,
  input  logic [NUM_PRIOR-1:0] credit_nz,
  output prior_t               sel,
  output logic                 reload
);

  logic [NUM_PRIOR-1:0] eligible;

  always_comb begin
    eligible = wrr_en ? (cnt_nz & credit_nz) : cnt_nz;
    reload   = wrr_en && (eligible == '0) && (cnt_nz != '0);
    // After a reload every non-empty queue has credit again.
    sel      = highest_set(reload ? cnt_nz : eligible);
  end

endmodule

// File: rtl/egress_wrr_scheduler.sv
// Per-output-port packet scheduler: counts committed packets per priority queue
// and hands one grant at a time to the port's read engine.
module egress_wrr_scheduler
  import hydra_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   wrr_en,
  input  logic   enq_vld,
  input  prior_t enq_prior,
  input  logic   ready,
  input  logic   xfer_done,
  output logic   grant_vld,
  output prior_t grant_prior,
  output logic   busy,
  output logic   pending,
  output logic   overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sched_state_t state_reg, state_next;
  logic [CNT_W-1:0]    count_reg  [NUM_PRIOR];
  logic [WEIGHT_W-1:0] credit_reg [NUM_PRIOR];
  logic [NUM_PRIOR-1:0] cnt_nz, credit_nz, drop_vec;

  logic   ready_pend_reg, ready_pend_next;
  logic   grant_vld_reg, grant_vld_next;
  prior_t grant_prior_reg, grant_prior_next;
  logic   overflow_reg;
  logic   grant_fire, reload;
  prior_t sel;

  prior_select u_prior_select (
    .wrr_en    (wrr_en),
    .cnt_nz    (cnt_nz),
    .credit_nz (credit_nz),
    .sel       (sel),
    .reload    (reload)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PRIOR; gi++) begin : g_queue
      logic enq_hit, deq_hit;

      assign enq_hit       = enq_vld && (enq_prior == prior_t'(gi));
      assign deq_hit       = grant_fire && (sel == prior_t'(gi));
      assign cnt_nz[gi]    = (count_reg[gi] != '0);
      assign credit_nz[gi] = (credit_reg[gi] != '0);
      // A saturated queue can still absorb an enqueue if it is granted that cycle.
      assign drop_vec[gi]  = enq_hit && !deq_hit && (count_reg[gi] == CNT_MAX);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count_reg[gi] <= '0;
        end else if (enq_hit && !deq_hit && !drop_vec[gi]) begin
          count_reg[gi] <= count_reg[gi] + CNT_W'(1);
        end else if (deq_hit && !enq_hit) begin
          count_reg[gi] <= count_reg[gi] - CNT_W'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          credit_reg[gi] <= weight(prior_t'(gi));
        end else if (grant_fire && wrr_en) begin
          if (reload) begin
            credit_reg[gi] <= deq_hit ? weight(prior_t'(gi)) - WEIGHT_W'(1)
                                      : weight(prior_t'(gi));
          end else if (deq_hit) begin
            credit_reg[gi] <= credit_reg[gi] - WEIGHT_W'(1);
          end
        end
      end
    end
  endgenerate

  assign pending = |cnt_nz;

  always_comb begin
    state_next       = state_reg;
    grant_fire       = 1'b0;
    case (state_reg)
      IDLE: begin
        if ((ready || ready_pend_reg) && pending) begin
          grant_fire = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (xfer_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    grant_vld_next   = grant_fire;
    grant_prior_next = grant_fire ? sel : grant_prior_reg;
    // Requests seen while busy are remembered until the next grant.
    ready_pend_next  = grant_fire ? 1'b0 : (ready_pend_reg || ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      ready_pend_reg  <= 1'b0;
      grant_vld_reg   <= 1'b0;
      grant_prior_reg <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ready_pend_reg  <= ready_pend_next;
      grant_vld_reg   <= grant_vld_next;
      grant_prior_reg <= grant_prior_next;
      overflow_reg    <= overflow_reg || (|drop_vec);
    end
  end

  assign grant_vld   = grant_vld_reg;
  assign grant_prior = grant_prior_reg;
  assign busy        = (state_reg == BUSY);
  assign overflow    = overflow_reg;

endmodule
